ps2_kbd_fifo: RTL

Parametrised PS/2 keyboard front-end: receives PS/2 frames on the keyboard pins, handles E0/F0 prefixes, tracks shift/caps state, and pushes complete key events with optional ASCII into a first-word-fall-through FIFO that the processor side drains. It replaces the single-register scan-code path at the top level, so keystrokes are no longer lost while the consumer is busy.

---
 rtl/ps2_kbd_pkg.sv | 69 ++++++
 rtl/ps2_rx.sv | 113 +++++++++++
 rtl/ps2_kbd_fifo.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_kbd_pkg                                                              |
// | Scan constants, event record and scan-to-ASCII lookup for ps2_kbd_fifo.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_CAPS    = 8'h58;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] scan;
    logic [7:0] ascii;
  } kbd_event_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_CHECK = 2'd2
  } rx_state_t;

  // US layout, set-2 make codes; alt is the shifted symbol for the digit row.
  function automatic logic [7:0] kbd_ascii(input logic [7:0] sc, input logic shift,
                                           input logic caps);
    logic [7:0] base;
    logic [7:0] alt;
    logic       letter;
    base = 8'h00;
    alt  = 8'h00;
    case (sc)
      8'h1C: base = "a";  8'h32: base = "b";  8'h21: base = "c";  8'h23: base = "d";
      8'h24: base = "e";  8'h2B: base = "f";  8'h34: base = "g";  8'h33: base = "h";
      8'h43: base = "i";  8'h3B: base = "j";  8'h42: base = "k";  8'h4B: base = "l";
      8'h3A: base = "m";  8'h31: base = "n";  8'h44: base = "o";  8'h4D: base = "p";
      8'h15: base = "q";  8'h2D: base = "r";  8'h1B: base = "s";  8'h2C: base = "t";
      8'h3C: base = "u";  8'h2A: base = "v";  8'h1D: base = "w";  8'h22: base = "x";
      8'h35: base = "y";  8'h1A: base = "z";
      8'h16: begin base = "1"; alt = "!"; end
      8'h1E: begin base = "2"; alt = "@"; end
      8'h26: begin base = "3"; alt = "#"; end
      8'h25: begin base = "4"; alt = "$"; end
      8'h2E: begin base = "5"; alt = "%"; end
      8'h36: begin base = "6"; alt = "^"; end
      8'h3D: begin base = "7"; alt = "&"; end
      8'h3E: begin base = "8"; alt = "*"; end
      8'h46: begin base = "9"; alt = "("; end
      8'h45: begin base = "0"; alt = ")"; end
      8'h29: base = 8'h20;
      8'h5A: base = 8'h0D;
      8'h66: base = 8'h08;
      default: base = 8'h00;
    endcase
    letter = (base >= 8'h61) && (base <= 8'h7A);
    if (letter)
      return (shift ^ caps) ? (base - 8'h20) : base;
    else if (shift && (alt != 8'h00))
      return alt;
    else
      return base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_rx                                                                   |
// | PS/2 pin synchronisers, clock glitch filter and 11-bit frame receiver.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int c_flt_w = $clog2(FILTER_LEN + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_flt_w-1:0] c_flt_max = c_flt_w'(FILTER_LEN - 1);
  localparam logic [c_to_w-1:0]  c_to_max  = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [1:0]         r_c_sync;
  logic [1:0]         r_d_sync;
  logic               r_c_filt;
  logic [c_flt_w-1:0] r_flt_cnt;
  logic [c_to_w-1:0]  r_to_cnt;
  logic [10:0]        r_shift;
  logic [3:0]         r_bit_cnt;
  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic               w_accept;
  logic               w_fall;
  logic               w_timeout;
  logic               w_frame_ok;

  assign w_accept   = (r_c_sync[1] != r_c_filt) && (r_flt_cnt == c_flt_max);
  assign w_fall     = w_accept && r_c_filt;
  assign w_timeout  = (r_state == RX_SHIFT) && !w_fall && (r_to_cnt == c_to_max);
  assign w_frame_ok = !r_shift[0] && r_shift[10] && (^r_shift[9:1]);
  assign rx_byte    = r_shift[8:1];

  // Lines idle high, so the synchronisers and filter reset to 1.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_c_sync  <= 2'b11;
      r_d_sync  <= 2'b11;
      r_c_filt  <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_c_sync <= {r_c_sync[0], ps2c};
      r_d_sync <= {r_d_sync[0], ps2d};
      if (r_c_sync[1] == r_c_filt) begin
        r_flt_cnt <= '0;
      end else if (w_accept) begin
        r_flt_cnt <= '0;
        r_c_filt  <= r_c_sync[1];
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RX_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fall && (r_state != RX_CHECK)) begin
        r_shift   <= {r_d_sync[1], r_shift[10:1]};
        r_bit_cnt <= (r_state == RX_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
      end
      if ((r_state != RX_SHIFT) || w_fall)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    byte_done   = 1'b0;
    frame_err   = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) w_state_nxt = RX_SHIFT;
      end
      RX_SHIFT: begin
        if (w_timeout) begin
          w_state_nxt = RX_IDLE;
          frame_err   = 1'b1;
        end else if (w_fall && (r_bit_cnt == 4'd10)) begin
          w_state_nxt = RX_CHECK;
        end
      end
      RX_CHECK: begin
        w_state_nxt = RX_IDLE;
        byte_done   = w_frame_ok;
        frame_err   = !w_frame_ok;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ps2_kbd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_kbd_fifo                                                             |
// | PS/2 keyboard front-end: prefix decode, modifiers, ASCII, event FWFT FIFO.|
// | Optional feature macro: PS2_KBD_ASCII_EN (modifier tracking + ASCII).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ps2_kbd_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16,
  parameter int PUSH_BREAK     = 0
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd_en,
  output logic       valid,
  output logic       ext,
  output logic       brk,
  output logic [7:0] scan_code,
  output logic [7:0] ascii,
  output logic       full,
  output logic       overflow,
  output logic [7:0] err_cnt,
  output logic [1:0] mods
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0] c_depth = (c_aw + 1)'(FIFO_DEPTH);

  logic       w_byte_done;
  logic [7:0] w_rx_byte;
  logic       w_frame_err;
  logic [7:0] w_ascii;
  logic       r_ext_pend;
  logic       r_brk_pend;
  logic       r_evt_fire;
  kbd_event_t r_evt;
  logic       w_push;
  logic       w_wr;
  logic       w_rd;
  logic [7:0] r_err_cnt;
  logic       r_overflow;
  kbd_event_t r_mem [FIFO_DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  kbd_event_t w_head;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .byte_done (w_byte_done),
    .rx_byte   (w_rx_byte),
    .frame_err (w_frame_err)
  );

  // Prefix bytes only arm flags; every other byte closes an event.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      r_evt_fire <= 1'b0;
      r_evt      <= '0;
    end else begin
      r_evt_fire <= 1'b0;
      if (w_byte_done) begin
        if (w_rx_byte == SC_E0) begin
          r_ext_pend <= 1'b1;
        end else if (w_rx_byte == SC_F0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_evt_fire <= 1'b1;
          r_evt      <= '{ext: r_ext_pend, brk: r_brk_pend, scan: w_rx_byte, ascii: w_ascii};
          r_ext_pend <= 1'b0;
          r_brk_pend <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_KBD_ASCII_EN
  logic r_lshift;
  logic r_rshift;
  logic r_caps;
  logic r_caps_held;
  logic w_shift;

  assign w_shift = r_lshift | r_rshift;
  assign w_ascii = (r_ext_pend || r_brk_pend) ? 8'h00 : kbd_ascii(w_rx_byte, w_shift, r_caps);
  assign mods    = {r_caps, w_shift};

  // Caps toggles once per physical press; typematic repeats see r_caps_held.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_lshift    <= 1'b0;
      r_rshift    <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
    end else if (r_evt_fire && !r_evt.ext) begin
      case (r_evt.scan)
        SC_LSHIFT: r_lshift <= !r_evt.brk;
        SC_RSHIFT: r_rshift <= !r_evt.brk;
        SC_CAPS: begin
          if (r_evt.brk) begin
            r_caps_held <= 1'b0;
          end else if (!r_caps_held) begin
            r_caps      <= !r_caps;
            r_caps_held <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign w_ascii = 8'h00;
  assign mods    = 2'b00;
`endif

  assign w_push = r_evt_fire && ((PUSH_BREAK != 0) || !r_evt.brk);
  assign valid  = (r_count != '0);
  assign full   = (r_count == c_depth);
  assign w_rd   = rd_en && valid;
  assign w_wr   = w_push && (!full || w_rd);

  always_ff @(posedge sysclk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_evt;
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_err_cnt  <= 8'h00;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_overflow <= 1'b1;
      if (w_frame_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign w_head    = valid ? r_mem[r_rd_ptr] : '0;
  assign ext       = w_head.ext;
  assign brk       = w_head.brk;
  assign scan_code = w_head.scan;
  assign ascii     = w_head.ascii;
  assign overflow  = r_overflow;
  assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
